multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath: one shared memory, ALU and register file, reused across FETCH/DECODE/EXEC/MEM/WB states.
- Supports R-format (000000), ADDIU (001001), ORI (001101), LW (100011) and SW (101011).
- Generates per-state datapath controls.
- Adds memory wait-state handling, a memory timeout watchdog and a retired-instruction counter.

Parameters:
- WAIT_LIMIT, 15: number of consecutive mem_ready=0 cycles in one memory state before timeout; 0 disables the watchdog.
- CNT_W, 32: width of retired_cnt.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_code  in  6  IR[31:26]; sampled only in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- pc_w  out  1  PC write enable
- ir_w  out  1  instruction register write enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_r  out  1  memory read strobe
- mem_w  out  1  memory write strobe
- mem_to_reg  out  1  register write data: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- reg_w  out  1  register file write enable
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B input: 00 = B register, 01 = constant 4, 10 = immediate
- alu_op  out  2  00 = add, 10 = use funct, 11 = or
- ext_zero  out  1  1 = zero-extend the immediate (ORI), 0 = sign-extend
- instr_done  out  1  one-cycle pulse when an instruction retires
- retired_cnt  out  CNT_W  count of retired instructions
- err  out  1  sticky error flag
- state  out  4  current state encoding, for debug

Behaviour:
- States and encodings: RST_S=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, ERROR=11.
- Registered state: state, op_q[5:0] (opcode latched in DECODE), wait_cnt, retired_cnt. Control outputs are combinational from state, op_q and mem_ready.
- Reset (async, rst_n=0): state=RST_S, op_q=0, wait_cnt=0, retired_cnt=0. Every output is 0 in RST_S. RST_S always moves to FETCH on the next edge.
- Any output not listed for a state is 0 in that state.
- FETCH: i_or_d=0, mem_r=1, alu_src_a=0, alu_src_b=01, alu_op=00.
  - ir_w and pc_w are asserted only in the cycle mem_ready=1; the state then moves to DECODE.
  - Otherwise the state holds in FETCH.
- DECODE: latch op_q<=op_code. Next state:
  - R-format -> R_EXEC
  - ADDIU or ORI -> I_EXEC
  - LW or SW -> MEM_ADDR
  - any other opcode -> see ILLEGAL_TRAP_EN
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: i_or_d=1, mem_r=1. Moves to MEM_WB when mem_ready=1, otherwise holds.
- MEM_WB: reg_w=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEM_WRITE: i_or_d=1, mem_w=1. When mem_ready=1: instr_done=1 and next state FETCH. Otherwise holds.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_w=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10.
  - alu_op=00 and ext_zero=0 for ADDIU.
  - alu_op=11 and ext_zero=1 for ORI.
  - Next state I_WB.
- I_WB: reg_w=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- Latency at zero wait states:
  - R-format, ADDIU, ORI, SW: 4 cycles, FETCH to FETCH.
  - LW: 5 cycles.
  - Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds 1 cycle.
- wait_cnt:
  - Cleared on entry to each memory state and whenever mem_ready=1.
  - Increments on each cycle in a memory state with mem_ready=0.
  - If WAIT_LIMIT!=0, wait_cnt==WAIT_LIMIT-1 and mem_ready=0: next state ERROR (timeout after exactly WAIT_LIMIT stalled cycles).
  - If mem_ready rises in that same cycle, it completes normally.
- ERROR: all control outputs 0, err=1. The state stays in ERROR until rst_n is asserted.
- retired_cnt increments on every instr_done cycle and wraps from 2^CNT_W-1 to 0.
- op_code changing outside DECODE has no effect.
- rst_n asserted mid-instruction returns to RST_S immediately. Strobes drop asynchronously; retired_cnt clears.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an unsupported opcode in DECODE sends the state to ERROR, with err=1 from the next cycle.
- Not defined: an unsupported opcode is a NOP. DECODE asserts instr_done=1 and returns to FETCH; the instruction counts as retired and err stays 0.

Test Plan:
- Reset, then mem_ready=1 held, op_code=000000 -> states RST_S, FETCH, DECODE, R_EXEC, R_WB, FETCH. In R_WB: reg_w=1, reg_dst=1, instr_done=1. retired_cnt=1.
- LW (100011) with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles. MEM_WB has mem_to_reg=1 and reg_w=1. 8 cycles FETCH to FETCH.
- ORI (001101) then ADDIU (001001), mem_ready=1 -> I_EXEC shows alu_op=11, ext_zero=1, then alu_op=00, ext_zero=0. retired_cnt=2.
- SW with mem_ready=0 for 15 cycles in MEM_WRITE (WAIT_LIMIT=15) -> ERROR on the 16th cycle, err=1, all strobes 0. Holds until rst_n=0.
- op_code=111111:
  - With ILLEGAL_TRAP_EN -> ERROR, err=1.
  - Without -> instr_done pulse in DECODE, back to FETCH, err=0.
- rst_n dropped mid MEM_WRITE with retired_cnt=5 -> mem_w=0 immediately, state=0, retired_cnt=0. FETCH one cycle after release.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl_fsm                                                      |
// | Multi-cycle MIPS control sequencer with memory wait states, a memory     |
// | timeout watchdog and a retired-instruction counter.                      |
// | Optional macro ILLEGAL_TRAP_EN: unsupported opcodes trap to ERROR        |
// | instead of retiring as a NOP.                                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_ctrl_fsm #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op_code,
  input  logic             mem_ready,
  output logic             pc_w,
  output logic             ir_w,
  output logic             i_or_d,
  output logic             mem_r,
  output logic             mem_w,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_w,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             ext_zero,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             err,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    RST_S     = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    I_EXEC    = 4'd9,
    I_WB      = 4'd10,
    ERROR     = 4'd11
  } state_t;

  localparam logic [5:0] c_OP_R     = 6'b000000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  // The counter only needs to reach WAIT_LIMIT-1; it saturates when the watchdog is off.
  localparam int c_WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = (WAIT_LIMIT > 0) ? c_WAIT_W'(WAIT_LIMIT - 1) : '0;
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [5:0]          r_op_q;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]    r_retired_cnt;
  logic                w_mem_state;
  logic                w_timeout;

  assign w_mem_state = (r_state == FETCH) || (r_state == MEM_READ) || (r_state == MEM_WRITE);
  assign w_timeout   = (WAIT_LIMIT != 0) && w_mem_state && !mem_ready && (r_wait_cnt == c_WAIT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    pc_w        = 1'b0;
    ir_w        = 1'b0;
    i_or_d      = 1'b0;
    mem_r       = 1'b0;
    mem_w       = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_w       = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    ext_zero    = 1'b0;
    instr_done  = 1'b0;
    err         = 1'b0;

    case (r_state)
      RST_S: w_state_nxt = FETCH;

      FETCH: begin
        mem_r     = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          pc_w        = 1'b1;
          ir_w        = 1'b1;
          w_state_nxt = DECODE;
        end else if (w_timeout) begin
          w_state_nxt = ERROR;
        end
      end

      DECODE: begin
        case (op_code)
          c_OP_R:               w_state_nxt = R_EXEC;
          c_OP_ADDIU, c_OP_ORI: w_state_nxt = I_EXEC;
          c_OP_LW, c_OP_SW:     w_state_nxt = MEM_ADDR;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            w_state_nxt = ERROR;
`else
            instr_done  = 1'b1;
            w_state_nxt = FETCH;
`endif
          end
        endcase
      end

      MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        w_state_nxt = (r_op_q == c_OP_SW) ? MEM_WRITE : MEM_READ;
      end

      MEM_READ: begin
        i_or_d = 1'b1;
        mem_r  = 1'b1;
        if (mem_ready)      w_state_nxt = MEM_WB;
        else if (w_timeout) w_state_nxt = ERROR;
      end

      MEM_WB: begin
        reg_w       = 1'b1;
        mem_to_reg  = 1'b1;
        instr_done  = 1'b1;
        w_state_nxt = FETCH;
      end

      MEM_WRITE: begin
        i_or_d = 1'b1;
        mem_w  = 1'b1;
        if (mem_ready) begin
          instr_done  = 1'b1;
          w_state_nxt = FETCH;
        end else if (w_timeout) begin
          w_state_nxt = ERROR;
        end
      end

      R_EXEC: begin
        alu_src_a   = 1'b1;
        alu_op      = 2'b10;
        w_state_nxt = R_WB;
      end

      R_WB: begin
        reg_w       = 1'b1;
        reg_dst     = 1'b1;
        instr_done  = 1'b1;
        w_state_nxt = FETCH;
      end

      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (r_op_q == c_OP_ORI) begin
          alu_op   = 2'b11;
          ext_zero = 1'b1;
        end
        w_state_nxt = I_WB;
      end

      I_WB: begin
        reg_w       = 1'b1;
        instr_done  = 1'b1;
        w_state_nxt = FETCH;
      end

      ERROR: err = 1'b1;

      // Unused encodings are treated as a fault rather than silently recovering.
      default: w_state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RST_S;
      r_op_q        <= 6'd0;
      r_wait_cnt    <= '0;
      r_retired_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == DECODE) r_op_q <= op_code;
      // No memory state hands over to another with mem_ready low, so this also clears on entry.
      if (w_mem_state && !mem_ready)
        r_wait_cnt <= (r_wait_cnt == c_WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
      else
        r_wait_cnt <= '0;
      if (instr_done) r_retired_cnt <= r_retired_cnt + 1'b1;
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_ctrl_fsm                                                   |
// | Randomized self-checking bench: an instruction-level model expands each  |
// | instruction into its expected per-cycle state and control pattern.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl_fsm;

  localparam int WAIT_LIMIT = 15;
  localparam int CNT_W      = 4;

  localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MADDR = 4'd3,
                         S_MREAD = 4'd4, S_MWB = 4'd5, S_MWRITE = 4'd6, S_REXEC = 4'd7,
                         S_RWB = 4'd8, S_IEXEC = 4'd9, S_IWB = 4'd10, S_ERROR = 4'd11;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDIU = 6'b001001, OP_ORI = 6'b001101,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;

  // {alu_src_a, alu_src_b, pc_w, ir_w, i_or_d, mem_r, mem_w, mem_to_reg, reg_dst, reg_w,
  //  alu_op, ext_zero, instr_done, err}
  localparam logic [15:0] K_NONE    = 16'h0000;
  localparam logic [15:0] K_F_STALL = 16'b0_01_0_0_0_1_0_0_0_0_00_0_0_0;
  localparam logic [15:0] K_F_RDY   = 16'b0_01_1_1_0_1_0_0_0_0_00_0_0_0;
  localparam logic [15:0] K_NOP     = 16'b0_00_0_0_0_0_0_0_0_0_00_0_1_0;
  localparam logic [15:0] K_MADDR   = 16'b1_10_0_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [15:0] K_MREAD   = 16'b0_00_0_0_1_1_0_0_0_0_00_0_0_0;
  localparam logic [15:0] K_MWB     = 16'b0_00_0_0_0_0_0_1_0_1_00_0_1_0;
  localparam logic [15:0] K_MW_STL  = 16'b0_00_0_0_1_0_1_0_0_0_00_0_0_0;
  localparam logic [15:0] K_MW_RDY  = 16'b0_00_0_0_1_0_1_0_0_0_00_0_1_0;
  localparam logic [15:0] K_REXEC   = 16'b1_00_0_0_0_0_0_0_0_0_10_0_0_0;
  localparam logic [15:0] K_RWB     = 16'b0_00_0_0_0_0_0_0_1_1_00_0_1_0;
  localparam logic [15:0] K_ADDIU   = 16'b1_10_0_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [15:0] K_ORI     = 16'b1_10_0_0_0_0_0_0_0_0_11_1_0_0;
  localparam logic [15:0] K_IWB     = 16'b0_00_0_0_0_0_0_0_0_1_00_0_1_0;
  localparam logic [15:0] K_ERR     = 16'b0_00_0_0_0_0_0_0_0_0_00_0_0_1;

  logic             clk, rst_n, mem_ready;
  logic [5:0]       op_code;
  logic             pc_w, ir_w, i_or_d, mem_r, mem_w, mem_to_reg, reg_dst, reg_w;
  logic             alu_src_a, ext_zero, instr_done, err;
  logic [1:0]       alu_src_b, alu_op;
  logic [CNT_W-1:0] retired_cnt;
  logic [3:0]       state;
  logic [15:0]      act_ctl;

  assign act_ctl = {alu_src_a, alu_src_b, pc_w, ir_w, i_or_d, mem_r, mem_w, mem_to_reg,
                    reg_dst, reg_w, alu_op, ext_zero, instr_done, err};

  multicycle_ctrl_fsm #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
    .pc_w(pc_w), .ir_w(ir_w), .i_or_d(i_or_d), .mem_r(mem_r), .mem_w(mem_w),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_w(reg_w), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_zero(ext_zero), .instr_done(instr_done),
    .retired_cnt(retired_cnt), .err(err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic        dec;
    logic [5:0]  op;
    logic [15:0] ctl;
  } step_t;

  step_t            q[$];
  logic [CNT_W-1:0] exp_cnt;
  int               n_checks = 0;
  int               n_pass   = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic void push(input logic [3:0] s, input logic m, input logic [15:0] c);
    q.push_back('{st: s, mr: m, dec: 1'b0, op: 6'd0, ctl: c});
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_R || op == OP_ADDIU || op == OP_ORI || op == OP_LW || op == OP_SW;
  endfunction

  // Expand one instruction into its cycle-by-cycle expectation.
  function automatic void plan(input logic [5:0] op, input int fw, input int mw);
    logic [15:0] dctl;
    for (int i = 0; i < fw; i++) push(S_FETCH, 1'b0, K_F_STALL);
    push(S_FETCH, 1'b1, K_F_RDY);
`ifdef ILLEGAL_TRAP_EN
    dctl = K_NONE;
`else
    dctl = is_legal(op) ? K_NONE : K_NOP;
`endif
    q.push_back('{st: S_DECODE, mr: rb(), dec: 1'b1, op: op, ctl: dctl});
    case (op)
      OP_R:     begin push(S_REXEC, rb(), K_REXEC); push(S_RWB, rb(), K_RWB); end
      OP_ADDIU: begin push(S_IEXEC, rb(), K_ADDIU); push(S_IWB, rb(), K_IWB); end
      OP_ORI:   begin push(S_IEXEC, rb(), K_ORI);   push(S_IWB, rb(), K_IWB); end
      OP_LW: begin
        push(S_MADDR, rb(), K_MADDR);
        for (int i = 0; i < mw; i++) push(S_MREAD, 1'b0, K_MREAD);
        push(S_MREAD, 1'b1, K_MREAD);
        push(S_MWB, rb(), K_MWB);
      end
      OP_SW: begin
        push(S_MADDR, rb(), K_MADDR);
        for (int i = 0; i < mw; i++) push(S_MWRITE, 1'b0, K_MW_STL);
        push(S_MWRITE, 1'b1, K_MW_RDY);
      end
      default: ;
    endcase
  endfunction

  // Replay the queued expectation; called at posedge+1, returns at posedge+1.
  task automatic run_queue(input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      op_code   = s.dec ? s.op : 6'($urandom);
      mem_ready = s.mr;
      #1;
      n_checks++;
      if (state !== s.st) $display("FAIL %s state: got %0d expected %0d", tag, state, s.st);
      else n_pass++;
      n_checks++;
      if (act_ctl !== s.ctl)
        $display("FAIL %s ctl (state %0d): got %b expected %b", tag, s.st, act_ctl, s.ctl);
      else n_pass++;
      n_checks++;
      if (retired_cnt !== exp_cnt)
        $display("FAIL %s retired_cnt: got %0d expected %0d", tag, retired_cnt, exp_cnt);
      else n_pass++;
      if (s.ctl[1]) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op_code = 6'($urandom);
    #1;
    n_checks++;
    if (state !== S_RST || act_ctl !== K_NONE || retired_cnt !== '0)
      $display("FAIL reset_async: state %0d ctl %b cnt %0d expected 0/0/0", state, act_ctl, retired_cnt);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (state !== S_RST || act_ctl !== K_NONE)
      $display("FAIL reset_held: state %0d ctl %b expected 0/0", state, act_ctl);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (state !== S_FETCH) $display("FAIL reset_exit: state %0d expected %0d", state, S_FETCH);
    else n_pass++;
    exp_cnt = '0;
  endtask

  task automatic test_r_format();
    plan(OP_R, 0, 0);
    run_queue("r_format");
  endtask

  task automatic test_lw_wait();
    plan(OP_LW, 0, 3);
    run_queue("lw_wait");
  endtask

  task automatic test_ori_addiu();
    plan(OP_ORI, 0, 0);
    plan(OP_ADDIU, 0, 0);
    run_queue("ori_addiu");
  endtask

  task automatic test_sw_timeout();
    // One short of the limit must still complete, in FETCH and in MEM_WRITE.
    plan(OP_SW, 0, WAIT_LIMIT - 1);
    plan(OP_ADDIU, WAIT_LIMIT - 1, 0);
    push(S_FETCH, 1'b1, K_F_RDY);
    q.push_back('{st: S_DECODE, mr: rb(), dec: 1'b1, op: OP_SW, ctl: K_NONE});
    push(S_MADDR, rb(), K_MADDR);
    for (int i = 0; i < WAIT_LIMIT; i++) push(S_MWRITE, 1'b0, K_MW_STL);
    for (int i = 0; i < 4; i++) push(S_ERROR, rb(), K_ERR);
    run_queue("sw_timeout");
    test_reset();
  endtask

  task automatic test_illegal();
    plan(OP_BAD, 1, 0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) push(S_ERROR, rb(), K_ERR);
    run_queue("illegal_trap");
    test_reset();
`else
    plan(OP_R, 0, 0);
    run_queue("illegal_nop");
`endif
  endtask

  task automatic test_reset_mid();
    logic [5:0] ops[5];
    ops = '{OP_R, OP_ADDIU, OP_ORI, OP_LW, OP_SW};
    test_reset();
    for (int i = 0; i < 5; i++) plan(ops[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(0, 2));
    push(S_FETCH, 1'b1, K_F_RDY);
    q.push_back('{st: S_DECODE, mr: rb(), dec: 1'b1, op: OP_SW, ctl: K_NONE});
    push(S_MADDR, rb(), K_MADDR);
    push(S_MWRITE, 1'b0, K_MW_STL);
    push(S_MWRITE, 1'b0, K_MW_STL);
    run_queue("reset_mid_pre");
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_w !== 1'b1 || retired_cnt !== 4'd5)
      $display("FAIL reset_mid_before: mem_w %b cnt %0d expected 1/5", mem_w, retired_cnt);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_w !== 1'b0 || state !== S_RST || retired_cnt !== '0)
      $display("FAIL reset_mid_async: mem_w %b state %0d cnt %0d expected 0/0/0", mem_w, state, retired_cnt);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (state !== S_FETCH) $display("FAIL reset_mid_exit: state %0d expected %0d", state, S_FETCH);
    else n_pass++;
    exp_cnt = '0;
  endtask

  task automatic test_random();
    logic [5:0] op;
    // More than 2^CNT_W retirements so the counter wraps.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: op = OP_R;
        1: op = OP_ADDIU;
        2: op = OP_ORI;
        3: op = OP_LW;
        4: op = OP_SW;
`ifdef ILLEGAL_TRAP_EN
        default: op = OP_R;
`else
        default: op = 6'($urandom) | 6'b000110;
`endif
      endcase
      plan(op, $urandom_range(0, 3), $urandom_range(0, 5));
      run_queue("random");
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; op_code = 6'd0; exp_cnt = '0;
    @(posedge clk); #1;
    test_reset();
    test_r_format();
    test_lw_wait();
    test_ori_addiu();
    test_sw_timeout();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
